iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, >= 4.
REQ-002 Derived localparam SW = clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 mode  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101-111 reserved.
REQ-007 shamt  input  SW  shift/rotate distance, unsigned.
REQ-008 din  input  WIDTH  operand.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse, result valid.
REQ-011 dout  output  WIDTH  result register.

Function
REQ-012 FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT.
REQ-013 Start accepted at edge T0 when start=1 in IDLE or DONE: capture din into dout, latch mode, load counter with shamt.
REQ-014 At T0, next state SHIFT if shamt>0 and mode valid, else DONE.
REQ-015 SHIFT: each edge applies one 1-bit step to dout per latched mode and decrements counter; the edge taking counter 1->0 moves to DONE.
REQ-016 Steps: SLL {d[W-2:0],0}; SRL {0,d[W-1:1]}; SRA {d[W-1],d[W-1:1]}; ROR {d[0],d[W-1:1]}; ROL {d[W-2:0],d[W-1]}.
REQ-017 done=1 exactly in the cycle following edge T0+shamt (shamt=0: cycle after T0); latency independent of WIDTH.
REQ-018 Reserved mode: dout=din unchanged, done after T0, shamt ignored.
REQ-019 DONE lasts one cycle, then IDLE unless start=1 (back-to-back accepted from DONE).
REQ-020 start, mode, shamt, din ignored while busy=1; latched values not disturbed.
REQ-021 dout holds its value in IDLE and DONE until next accepted start.

Reset
REQ-022 rst=1 at an edge: state IDLE, dout=0, counter=0, busy=0, done=0; overrides start.
REQ-023 rst mid-SHIFT aborts operation; no done pulse for it.

Configuration
REQ-024 Macro ITER_SHIFTER_ROTATE_EN defined: modes 011/100 perform ROR/ROL per REQ-016.
REQ-025 Macro undefined: 011/100 treated as reserved per REQ-018; rotate logic absent.

Structure
REQ-026 Package iter_shifter_pkg SHALL hold mode encodings and FSM state encoding.
REQ-027 Sub-module shift_step (combinational, WIDTH param): one-bit step per mode; instantiated once.

Verification
REQ-028 WIDTH=32, SLL, din=0x0000_0001, shamt=5 -> done cycle after T0+5, dout=0x0000_0020, busy high 5 cycles.
REQ-029 SRA, din=0x8000_0000, shamt=4 -> dout=0xF800_0000; SRL same -> 0x0800_0000.
REQ-030 ROTATE_EN defined, ROR, din=0x0000_0003, shamt=1 -> dout=0x8000_0001; undefined -> dout=0x0000_0003, done after T0.
REQ-031 shamt=0 and mode=111 -> dout=din, done cycle after T0, busy never high.
REQ-032 rst asserted during SHIFT of shamt=20 at 3rd cycle -> dout=0, busy=0, no done; new start with shamt=2 completes normally.
REQ-033 start held high through SHIFT with changing din -> ignored; start in DONE cycle accepted back-to-back with correct second result.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// -----------------------------------------------------------------------------
// iter_shifter_pkg
// Shared definitions for the iterative shifter: operation encodings, FSM state
// encoding and a helper that decides whether an operation code is executable
// in the current build.
//
// Build option: ITER_SHIFTER_ROTATE_EN
//   defined   -> ROR/ROL codes are executable operations
//   undefined -> ROR/ROL codes behave like the reserved codes (operand passes
//                through unchanged)
// -----------------------------------------------------------------------------
package iter_shifter_pkg;

    localparam int MODE_W = 3;

    // Operation codes carried on the mode input; 101-111 are reserved.
    typedef enum logic [MODE_W-1:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROR = 3'b011,
        MODE_ROL = 3'b100
    } mode_e;

    // Controller states; busy is asserted only in ST_SHIFT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when the code selects an operation that actually moves bits.
    function automatic logic mode_is_valid(input logic [MODE_W-1:0] m);
`ifdef ITER_SHIFTER_ROTATE_EN
        return (m <= MODE_ROL);
`else
        return (m <= MODE_SRA);
`endif
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// -----------------------------------------------------------------------------
// iter_shifter_if
// Request/result bundle of the iterative shifter.
//   start  : request, sampled only while the shifter is not busy
//   mode   : operation code (see iter_shifter_pkg::mode_e)
//   shamt  : shift/rotate distance, unsigned, $clog2(WIDTH) bits
//   din    : operand
//   busy   : operation in progress
//   done   : one-cycle pulse, dout holds the result
//   dout   : result register
// Modports: master = requester, slave = shifter.
// -----------------------------------------------------------------------------
interface iter_shifter_if
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic              start;
    logic [MODE_W-1:0] mode;
    logic [SW-1:0]     shamt;
    logic [WIDTH-1:0]  din;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  dout;

    modport master (
        output start, mode, shamt, din,
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, shamt, din,
        output busy, done, dout
    );

endinterface

// File: rtl/iter_shifter_shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-bit step of the selected operation.
//   mode : operation code
//   d    : current value
//   q    : value after one 1-bit step (unchanged for non-executable codes)
// Build option ITER_SHIFTER_ROTATE_EN adds the rotate steps; without it the
// rotate codes fall through to the pass-through default.
// -----------------------------------------------------------------------------
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);

    always_comb begin
        q = d;
        case (mode)
            MODE_SLL: q = {d[WIDTH-2:0], 1'b0};
            MODE_SRL: q = {1'b0, d[WIDTH-1:1]};
            MODE_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
            MODE_ROR: q = {d[0], d[WIDTH-1:1]};
            MODE_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
`endif
            default:  q = d;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// -----------------------------------------------------------------------------
// iter_shifter
// Iterative shifter/rotator: one bit position per clock, so a shift by N takes
// N cycles in SHIFT regardless of WIDTH.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : iter_shifter_if.slave (start/mode/shamt/din in, busy/done/dout out)
// Build option ITER_SHIFTER_ROTATE_EN enables ROR/ROL; otherwise those codes
// are treated as reserved and the operand is returned unchanged.
// -----------------------------------------------------------------------------
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    iter_shifter_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [WIDTH-1:0]  step_out;
    logic              accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode (mode_q),
        .d    (dout_q),
        .q    (step_out)
    );

    // A request is only seen outside SHIFT, so inputs cannot disturb a
    // running operation.
    assign accept = bus.start && (state_q != ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Zero-distance and non-executable requests skip SHIFT entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if ((bus.shamt != '0) && mode_is_valid(bus.mode))
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SW'(1))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, step once per SHIFT cycle, otherwise hold.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (accept) begin
            dout_d = bus.din;
            cnt_d  = bus.shamt;
            mode_d = bus.mode;
        end else if (state_q == ST_SHIFT) begin
            dout_d = step_out;
            cnt_d  = cnt_q - SW'(1);
        end
    end

    always_comb begin
        bus.busy = (state_q == ST_SHIFT);
        bus.done = (state_q == ST_DONE);
        bus.dout = dout_q;
    end

endmodule

// File: tb/tb_iter_shifter.sv
// -----------------------------------------------------------------------------
// tb_iter_shifter
// Self-checking bench for iter_shifter at WIDTH=32. Expected results and
// latencies come from an arithmetic reference model (whole-word shifts and
// rotates), not from a bit-by-bit replay of the design.
// -----------------------------------------------------------------------------
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int SW    = $clog2(WIDTH);

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    iter_shifter_if #(.WIDTH(WIDTH)) bus ();

    iter_shifter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word result of the requested operation.
    function automatic logic [31:0] refResult(input logic [2:0] m, input int s, input logic [31:0] d);
        logic rotEn;
`ifdef ITER_SHIFTER_ROTATE_EN
        rotEn = 1'b1;
`else
        rotEn = 1'b0;
`endif
        case (m)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return 32'($signed(d) >>> s);
            3'd3: return !rotEn ? d : (s == 0 ? d : ((d >> s) | (d << (32 - s))));
            3'd4: return !rotEn ? d : (s == 0 ? d : ((d << s) | (d >> (32 - s))));
            default: return d;
        endcase
    endfunction

    // Reference: number of SHIFT cycles the request should take.
    function automatic int refLatency(input logic [2:0] m, input int s);
        int maxMode;
`ifdef ITER_SHIFTER_ROTATE_EN
        maxMode = 4;
`else
        maxMode = 2;
`endif
        return (int'(m) <= maxMode) ? s : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issues one request from IDLE or DONE (called #1 after an edge) and
    // returns #1 after the edge that entered DONE. With noisy set, random
    // requests are driven throughout SHIFT; they must have no effect.
    task automatic applyStimulus(input logic [2:0] m, input int s, input logic [31:0] d,
                                 input bit noisy, input string tag);
        logic [31:0] expVal;
        int expLat;
        int cycles;
        int busyCount;
        expVal = refResult(m, s, d);
        expLat = refLatency(m, s);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.shamt = SW'(s);
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles    = 0;
        busyCount = 0;
        while (bus.done !== 1'b1 && cycles < 64) begin
            if (bus.busy === 1'b1) busyCount++;
            if (noisy) begin
                bus.start = 1'b1;
                bus.mode  = 3'($urandom_range(0, 7));
                bus.shamt = SW'($urandom);
                bus.din   = $urandom;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, " busyCycles"}, 32'(busyCount), 32'(expLat));
        checkOutput({tag, " dout"}, bus.dout, expVal);
        checkOutput({tag, " busyInDone"}, 32'(bus.busy), 32'd0);
    endtask

    // One cycle after DONE with no request: back to idle, no second pulse.
    task automatic idleStep(input string tag, input logic [31:0] expDout);
        @(posedge clk);
        #1;
        checkOutput({tag, " donePulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " holdDout"}, bus.dout, expDout);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  rm;
        int          rs;
        bus.start = 1'b0;
        bus.mode  = '0;
        bus.shamt = '0;
        bus.din   = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dout", bus.dout, 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'd0, 5, 32'h0000_0001, 1'b0, "sll5");
        checkOutput("sll5 literal", bus.dout, 32'h0000_0020);
        idleStep("sll5", 32'h0000_0020);
        applyStimulus(3'd2, 4, 32'h8000_0000, 1'b0, "sra4");
        checkOutput("sra4 literal", bus.dout, 32'hF800_0000);
        idleStep("sra4", 32'hF800_0000);
        applyStimulus(3'd1, 4, 32'h8000_0000, 1'b0, "srl4");
        checkOutput("srl4 literal", bus.dout, 32'h0800_0000);
        idleStep("srl4", 32'h0800_0000);
        applyStimulus(3'd3, 1, 32'h0000_0003, 1'b0, "ror1");
        idleStep("ror1", refResult(3'd3, 1, 32'h0000_0003));
        applyStimulus(3'd4, 31, 32'h8000_0001, 1'b0, "rol31");
        idleStep("rol31", refResult(3'd4, 31, 32'h8000_0001));
        applyStimulus(3'd7, 0, 32'h1234_5678, 1'b0, "rsv7");
        checkOutput("rsv7 literal", bus.dout, 32'h1234_5678);
        idleStep("rsv7", 32'h1234_5678);
        applyStimulus(3'd5, 9, 32'hCAFE_F00D, 1'b0, "rsv5");
        applyStimulus(3'd0, 0, 32'hA5A5_0F0F, 1'b0, "sll0b2b");
        applyStimulus(3'd1, 31, 32'hFFFF_FFFF, 1'b1, "srl31noisy");
        applyStimulus(3'd2, 7, 32'h9000_0000, 1'b1, "sra7b2b");
        idleStep("sra7b2b", refResult(3'd2, 7, 32'h9000_0000));

        // Abort a long shift partway through with reset.
        bus.start = 1'b1;
        bus.mode  = 3'd0;
        bus.shamt = SW'(20);
        bus.din   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort dout", bus.dout, 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1)
                checkOutput("abort lateActivity", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        applyStimulus(3'd0, 2, 32'h0000_0011, 1'b0, "afterAbort");
        idleStep("afterAbort", 32'h0000_0044);

        // Random operations, some with noise during SHIFT, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            rm = 3'($urandom_range(0, 7));
            rs = int'($urandom_range(0, WIDTH - 1));
            rd = $urandom;
            applyStimulus(rm, rs, rd, 1'($urandom), "rand");
            if ($urandom_range(0, 1) == 0)
                idleStep("rand", refResult(rm, rs, rd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the main sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
